// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO frame controller: FSM state encoding and
// the default parallel word width.
package sipo_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Handshake/bus bundle between a bit-serial source + word consumer (master)
// and the SIPO frame controller (slave).
interface sipo_frame_ctrl_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic             d_in;
    logic             d_in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             par_err;

    modport master (
        output start, d_in, d_in_valid, out_ready,
        input  out, out_valid, busy, overrun, par_err
    );

    modport slave (
        input  start, d_in, d_in_valid, out_ready,
        output out, out_valid, busy, overrun, par_err
    );
endinterface

// File: rtl/sipo_shift_core.sv
// WIDTH-bit right-shifting register: new bits enter at the MSB so the first
// bit of a frame ends up in bit 0 once WIDTH bits have been shifted in.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] sr_o
);
    logic [WIDTH-1:0] sr_q;

    // Clear has priority over shift so an aborted frame never keeps a bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           sr_q <= '0;
        else if (clear_i)    sr_q <= '0;
        else if (shift_en_i) sr_q <= {d_i, sr_q[WIDTH-1:1]};
    end

    assign sr_o = sr_q;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// SIPO frame controller: frames WIDTH serial bits into a word and offers it
// on a valid/ready handshake. Optional feature macro: PARITY_CHK_EN adds an
// even-parity bit after each word and reports the result on par_err.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic            clk,
    input  logic            reset,
    sipo_frame_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q;
    logic             overrun_q, overrun_d;
    logic             sr_clear, sr_shift;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_nxt;

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (sr_clear),
        .shift_en_i (sr_shift),
        .d_i        (bus.d_in),
        .sr_o       (sr)
    );

    // Word as it will look after the current bit is shifted in; lets the
    // last-bit edge load out directly with no extra cycle.
    assign word_nxt = {bus.d_in, sr[WIDTH-1:1]};

`ifdef PARITY_CHK_EN
    logic par_err_q, par_err_d;
`else
    logic sr_lsb_unused;
    assign sr_lsb_unused = sr[0];
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PARITY_CHK_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= (state_d != ST_IDLE);
            overrun_q   <= overrun_d;
`ifdef PARITY_CHK_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // Next-state, datapath control and output updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        sr_clear    = 1'b0;
        sr_shift    = 1'b0;
`ifdef PARITY_CHK_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SHIFT;
                    sr_clear  = 1'b1;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bus.start) begin
                    // Restart: the bit presented this cycle is discarded.
                    sr_clear = 1'b1;
                    cnt_d    = '0;
                end else if (bus.d_in_valid) begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
`ifdef PARITY_CHK_EN
                        state_d     = ST_PARITY;
`else
                        out_d       = word_nxt;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
`endif
                    end
                end
            end
            ST_PARITY: begin
`ifdef PARITY_CHK_EN
                if (bus.start) begin
                    state_d  = ST_SHIFT;
                    sr_clear = 1'b1;
                    cnt_d    = '0;
                end else if (bus.d_in_valid) begin
                    out_d       = sr;
                    out_valid_d = 1'b1;
                    par_err_d   = ^{sr, bus.d_in};
                    state_d     = ST_HOLD;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_HOLD: begin
                if (bus.d_in_valid) overrun_d = 1'b1;
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
`ifdef PARITY_CHK_EN
                    par_err_d   = 1'b0;
`endif
                    if (bus.start) begin
                        state_d   = ST_SHIFT;
                        sr_clear  = 1'b1;
                        cnt_d     = '0;
                        overrun_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
`ifdef PARITY_CHK_EN
    assign bus.par_err   = par_err_q;
`else
    assign bus.par_err   = 1'b0;
`endif
endmodule
